// File: rtl/multicycle_pkg.sv
// Shared types and constants for the LEGv8 multicycle sequencer: state and
// instruction-class encodings, opcode match patterns, ALU and sign-extend codes.
package multicycle_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CLS_NONE, CLS_LDUR, CLS_STUR, CLS_ADD, CLS_SUB, CLS_AND,
    CLS_ORR, CLS_ADDI, CLS_SUBI, CLS_CBZ, CLS_B
  } iclass_t;

  // Opcode patterns as value/care pairs; a 0 care bit is a don't-care position.
  typedef struct packed {
    logic [10:0] val;
    logic [10:0] care;
  } op_pat_t;

  localparam op_pat_t PAT_LDUR   = '{val: 11'b00111000010, care: 11'b00111111111};
  localparam op_pat_t PAT_STUR   = '{val: 11'b00111000000, care: 11'b00111111111};
  localparam op_pat_t PAT_ADDREG = '{val: 11'b00001011000, care: 11'b01011111000};
  localparam op_pat_t PAT_SUBREG = '{val: 11'b01001011000, care: 11'b01011111000};
  localparam op_pat_t PAT_ANDREG = '{val: 11'b00001010000, care: 11'b01111111000};
  localparam op_pat_t PAT_ORRREG = '{val: 11'b00101010000, care: 11'b01111111000};
  localparam op_pat_t PAT_ADDIMM = '{val: 11'b00010001000, care: 11'b01011111000};
  localparam op_pat_t PAT_SUBIMM = '{val: 11'b01010001000, care: 11'b01011111000};
  localparam op_pat_t PAT_CBZ    = '{val: 11'b00110100000, care: 11'b01111110000};
  localparam op_pat_t PAT_B      = '{val: 11'b00010100000, care: 11'b01111100000};

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  localparam logic [1:0] SIGN_IMM = 2'b00;
  localparam logic [1:0] SIGN_D   = 2'b01;
  localparam logic [1:0] SIGN_CB  = 2'b11;

  function automatic logic op_match(input logic [10:0] op, input op_pat_t p);
    return ((op ^ p.val) & p.care) == 11'b0;
  endfunction

  function automatic iclass_t classify(input logic [10:0] op);
    if (op_match(op, PAT_LDUR))   return CLS_LDUR;
    if (op_match(op, PAT_STUR))   return CLS_STUR;
    if (op_match(op, PAT_ADDREG)) return CLS_ADD;
    if (op_match(op, PAT_SUBREG)) return CLS_SUB;
    if (op_match(op, PAT_ANDREG)) return CLS_AND;
    if (op_match(op, PAT_ORRREG)) return CLS_ORR;
    if (op_match(op, PAT_ADDIMM)) return CLS_ADDI;
    if (op_match(op, PAT_SUBIMM)) return CLS_SUBI;
    if (op_match(op, PAT_CBZ))    return CLS_CBZ;
    if (op_match(op, PAT_B))      return CLS_B;
    return CLS_NONE;
  endfunction

  function automatic logic [3:0] alu_of(input iclass_t c);
    case (c)
      CLS_AND:                              return ALU_AND;
      CLS_ORR:                              return ALU_ORR;
      CLS_ADD, CLS_ADDI, CLS_LDUR, CLS_STUR: return ALU_ADD;
      CLS_SUB, CLS_SUBI:                    return ALU_SUB;
      CLS_CBZ:                              return ALU_PASSB;
      default:                              return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_ready_wait_counter.sv
// Wait-cycle counter shared by the instruction and data memory handshakes;
// expired is high while the count equals LIMIT.
module ready_wait_counter #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign expired = (count_q == LIMIT_C);

endmodule

// File: rtl/multicycle_control.sv
// LEGv8 multicycle sequencer: steps each instruction through FETCH/DECODE/EXEC/
// MEM/WB with ready handshakes on both memory ports and a shared wait timeout.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned CNT_W          = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_branch,
  output logic        reg2loc,
  output logic        alusrc,
  output logic        mem2reg,
  output logic        regwrite,
  output logic        memread,
  output logic        memwrite,
  output logic [3:0]  aluop,
  output logic [1:0]  signop,
  output logic        instr_done,
  output logic        illegal,
  output logic        timeout,
  output logic [2:0]  state
);

  state_t  state_q;
  iclass_t cls_q;
  iclass_t dec_cls;
  logic    illegal_q;
  logic    timeout_q;
  logic    ctr_clr;
  logic    ctr_en;
  logic    expired;

  always_comb dec_cls = classify(opcode);

  always_comb begin
    ctr_clr = ((state_q == ST_FETCH) && imem_ready) || ((state_q == ST_MEM) && dmem_ready);
    ctr_en  = ((state_q == ST_FETCH) && !imem_ready) || ((state_q == ST_MEM) && !dmem_ready);
  end

  ready_wait_counter #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait (
    .clk     (CLK),
    .rst     (Reset),
    .clear   (ctr_clr),
    .enable  (ctr_en),
    .expired (expired)
  );

  // Ready is tested before expiry so a ready on the final wait cycle still succeeds.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= ST_FETCH;
      cls_q     <= CLS_NONE;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem_ready) begin
            state_q <= ST_DECODE;
          end else if (expired) begin
            timeout_q <= 1'b1;
            state_q   <= ST_HALT;
          end
        end
        ST_DECODE: begin
          cls_q <= dec_cls;
          if (dec_cls == CLS_NONE) begin
            illegal_q <= 1'b1;
            state_q   <= ST_FETCH;
          end else begin
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (cls_q)
            CLS_LDUR, CLS_STUR: state_q <= ST_MEM;
            CLS_CBZ, CLS_B:     state_q <= ST_FETCH;
            default:            state_q <= ST_WB;
          endcase
        end
        ST_MEM: begin
          if (dmem_ready) begin
            state_q <= (cls_q == CLS_LDUR) ? ST_WB : ST_FETCH;
          end else if (expired) begin
            timeout_q <= 1'b1;
            state_q   <= ST_HALT;
          end
        end
        ST_WB:   state_q <= ST_FETCH;
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_HALT;
      endcase
    end
  end

  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_branch  = 1'b0;
    reg2loc    = 1'b0;
    alusrc     = 1'b0;
    mem2reg    = 1'b0;
    regwrite   = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    aluop      = '0;
    signop     = '0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    timeout    = 1'b0;
    state      = '0;
    if (!Reset) begin
      state   = state_q;
      illegal = illegal_q;
      timeout = timeout_q;
      case (state_q)
        ST_FETCH: begin
          ir_write = imem_ready;
          pc_write = imem_ready;
        end
        ST_DECODE: begin
          reg2loc    = (dec_cls == CLS_STUR) || (dec_cls == CLS_CBZ);
          instr_done = (dec_cls == CLS_NONE);
        end
        ST_EXEC: begin
          aluop  = alu_of(cls_q);
          alusrc = cls_q inside {CLS_ADDI, CLS_SUBI, CLS_LDUR, CLS_STUR};
          case (cls_q)
            CLS_LDUR, CLS_STUR: signop = SIGN_D;
            CLS_B: begin
              signop     = SIGN_D;
              pc_write   = 1'b1;
              pc_branch  = 1'b1;
              instr_done = 1'b1;
            end
            CLS_CBZ: begin
              signop     = SIGN_CB;
              pc_write   = zero;
              pc_branch  = zero;
              instr_done = 1'b1;
            end
            default: signop = SIGN_IMM;
          endcase
        end
        ST_MEM: begin
          aluop      = alu_of(cls_q);
          alusrc     = 1'b1;
          memread    = (cls_q == CLS_LDUR);
          memwrite   = (cls_q == CLS_STUR);
          instr_done = (cls_q == CLS_STUR) && dmem_ready;
        end
        ST_WB: begin
          regwrite   = 1'b1;
          mem2reg    = (cls_q == CLS_LDUR);
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
